// File: rtl/dm_stage.sv
`default_nettype none
// ============================================================================
// Module      : dm_stage
// Description : Data-memory pipeline stage between execute and writeback.
//               Issues loads/stores over a req/ack handshake to a variable
//               latency data memory, stalls upstream while an access is in
//               flight, aborts after TIMEOUT cycles without ack, and presents
//               a registered writeback bundle.
// Options     : `define DM_ALIGN_CHECK_EN adds a sticky align_err output and
//               rejects memory ops whose byte address is not word aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_stage #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       store_data_in,
  input  logic [4:0]        rd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic              flush,
  output logic              stall_flag,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [4:0]        rd_out_dm_wb,
  output logic              reg_write_out_dm_wb,
  output logic              mem_to_reg_out,
  output logic [31:0]       alu_result_out,
  output logic [31:0]       mem_data_out,
`ifdef DM_ALIGN_CHECK_EN
  output logic              timeout_err,
  output logic              align_err
`else
  output logic              timeout_err
`endif
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Last counter value before an unacknowledged access is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [31:0]         dmem_wdata_q, dmem_wdata_d;

  logic [4:0]          rd_out_q, rd_out_d;
  logic                reg_write_out_q, reg_write_out_d;
  logic                mem_to_reg_out_q, mem_to_reg_out_d;
  logic [31:0]         alu_result_out_q, alu_result_out_d;
  logic [31:0]         mem_data_q, mem_data_d;
  logic                timeout_err_q, timeout_err_d;

  // Writeback fields of the instruction parked while its access is in flight
  logic [4:0]          lat_rd_q, lat_rd_d;
  logic                lat_rw_q, lat_rw_d;
  logic                lat_m2r_q, lat_m2r_d;
  logic [31:0]         lat_alu_q, lat_alu_d;

`ifdef DM_ALIGN_CHECK_EN
  logic                align_err_q, align_err_d;
`endif

  logic                is_mem_op;
  logic                misaligned;

  assign is_mem_op = mem_read_in | mem_write_in;

`ifdef DM_ALIGN_CHECK_EN
  assign misaligned = |alu_result_in[1:0];
`else
  // Low byte-address bits are simply dropped when alignment is not checked.
  assign misaligned = 1'b0;
`endif

  // Next-state and next-output logic for the IDLE/ACCESS controller
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dmem_req_d       = dmem_req_q;
    dmem_we_d        = dmem_we_q;
    dmem_addr_d      = dmem_addr_q;
    dmem_wdata_d     = dmem_wdata_q;
    rd_out_d         = rd_out_q;
    reg_write_out_d  = reg_write_out_q;
    mem_to_reg_out_d = mem_to_reg_out_q;
    alu_result_out_d = alu_result_out_q;
    mem_data_d       = mem_data_q;
    timeout_err_d    = timeout_err_q;
    lat_rd_d         = lat_rd_q;
    lat_rw_d         = lat_rw_q;
    lat_m2r_d        = lat_m2r_q;
    lat_alu_d        = lat_alu_q;
`ifdef DM_ALIGN_CHECK_EN
    align_err_d      = align_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (flush) begin
          // Squashed instruction becomes a bubble
          reg_write_out_d  = 1'b0;
          mem_to_reg_out_d = 1'b0;
        end else if (!is_mem_op) begin
          rd_out_d         = rd_in;
          reg_write_out_d  = reg_write_in;
          alu_result_out_d = alu_result_in;
          mem_to_reg_out_d = 1'b0;
        end else if (misaligned) begin
          reg_write_out_d  = 1'b0;
          mem_to_reg_out_d = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
          align_err_d      = 1'b1;
`endif
        end else begin
          // Launch the access; a read+write combination is treated as a store
          dmem_req_d       = 1'b1;
          dmem_we_d        = mem_write_in;
          dmem_addr_d      = alu_result_in[ADDR_W+1:2];
          dmem_wdata_d     = store_data_in;
          lat_rd_d         = rd_in;
          lat_rw_d         = reg_write_in;
          lat_m2r_d        = mem_to_reg_in & ~mem_write_in;
          lat_alu_d        = alu_result_in;
          reg_write_out_d  = 1'b0;
          mem_to_reg_out_d = 1'b0;
          cnt_d            = '0;
          state_d          = ACCESS;
        end
      end

      ACCESS: begin
        if (dmem_ack) begin
          dmem_req_d       = 1'b0;
          state_d          = IDLE;
          rd_out_d         = lat_rd_q;
          reg_write_out_d  = lat_rw_q;
          mem_to_reg_out_d = lat_m2r_q;
          alu_result_out_d = lat_alu_q;
          if (!dmem_we_q) begin
            mem_data_d = dmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Memory never answered: drop the request and flag it
          dmem_req_d       = 1'b0;
          state_d          = IDLE;
          reg_write_out_d  = 1'b0;
          mem_to_reg_out_d = 1'b0;
          timeout_err_d    = 1'b1;
        end else begin
          cnt_d            = cnt_q + 16'd1;
          reg_write_out_d  = 1'b0;
          mem_to_reg_out_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= '0;
      dmem_wdata_q     <= '0;
      rd_out_q         <= '0;
      reg_write_out_q  <= 1'b0;
      mem_to_reg_out_q <= 1'b0;
      alu_result_out_q <= '0;
      mem_data_q       <= '0;
      timeout_err_q    <= 1'b0;
      lat_rd_q         <= '0;
      lat_rw_q         <= 1'b0;
      lat_m2r_q        <= 1'b0;
      lat_alu_q        <= '0;
`ifdef DM_ALIGN_CHECK_EN
      align_err_q      <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      dmem_req_q       <= dmem_req_d;
      dmem_we_q        <= dmem_we_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_wdata_q     <= dmem_wdata_d;
      rd_out_q         <= rd_out_d;
      reg_write_out_q  <= reg_write_out_d;
      mem_to_reg_out_q <= mem_to_reg_out_d;
      alu_result_out_q <= alu_result_out_d;
      mem_data_q       <= mem_data_d;
      timeout_err_q    <= timeout_err_d;
      lat_rd_q         <= lat_rd_d;
      lat_rw_q         <= lat_rw_d;
      lat_m2r_q        <= lat_m2r_d;
      lat_alu_q        <= lat_alu_d;
`ifdef DM_ALIGN_CHECK_EN
      align_err_q      <= align_err_d;
`endif
    end
  end

  assign stall_flag          = (state_q == ACCESS);
  assign dmem_req            = dmem_req_q;
  assign dmem_we             = dmem_we_q;
  assign dmem_addr           = dmem_addr_q;
  assign dmem_wdata          = dmem_wdata_q;
  assign rd_out_dm_wb        = rd_out_q;
  assign reg_write_out_dm_wb = reg_write_out_q;
  assign mem_to_reg_out      = mem_to_reg_out_q;
  assign alu_result_out      = alu_result_out_q;
  assign mem_data_out        = mem_data_q;
  assign timeout_err         = timeout_err_q;
`ifdef DM_ALIGN_CHECK_EN
  assign align_err           = align_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_stage
// Description : Self-checking bench for dm_stage. Directed scenarios followed
//               by randomized ALU/load/store/flush traffic; expectations come
//               from a transaction-level model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_stage;

  localparam int AW = 10;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   alu_result_in, store_data_in, dmem_rdata;
  logic [4:0]    rd_in;
  logic          mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic          flush, dmem_ack;
  logic          stall_flag, dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [4:0]    rd_out_dm_wb;
  logic          reg_write_out_dm_wb, mem_to_reg_out;
  logic [31:0]   alu_result_out, mem_data_out;
  logic          timeout_err;
`ifdef DM_ALIGN_CHECK_EN
  logic          align_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: last loaded word and sticky timeout flag
  logic [31:0] m_mem_data;
  logic        m_terr;

  dm_stage #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .alu_result_in       (alu_result_in),
    .store_data_in       (store_data_in),
    .rd_in               (rd_in),
    .mem_read_in         (mem_read_in),
    .mem_write_in        (mem_write_in),
    .reg_write_in        (reg_write_in),
    .mem_to_reg_in       (mem_to_reg_in),
    .flush               (flush),
    .stall_flag          (stall_flag),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_rdata          (dmem_rdata),
    .dmem_ack            (dmem_ack),
    .rd_out_dm_wb        (rd_out_dm_wb),
    .reg_write_out_dm_wb (reg_write_out_dm_wb),
    .mem_to_reg_out      (mem_to_reg_out),
    .alu_result_out      (alu_result_out),
    .mem_data_out        (mem_data_out),
`ifdef DM_ALIGN_CHECK_EN
    .timeout_err         (timeout_err),
    .align_err           (align_err)
`else
    .timeout_err         (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Non-memory instruction: one-cycle pass-through; a stray ack must be ignored
  task automatic alu_op(input logic [4:0] rd, input logic rw, input logic [31:0] alu);
    alu_result_in = alu;
    rd_in         = rd;
    reg_write_in  = rw;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    mem_to_reg_in = 1'($urandom);
    store_data_in = $urandom;
    flush         = 1'b0;
    dmem_ack      = 1'($urandom);
    dmem_rdata    = $urandom;
    @(posedge clk); #1;
    chk("alu_rd",     32'(rd_out_dm_wb),        32'(rd));
    chk("alu_rw",     32'(reg_write_out_dm_wb), 32'(rw));
    chk("alu_result", alu_result_out,           alu);
    chk("alu_m2r",    32'(mem_to_reg_out),      32'd0);
    chk("alu_stall",  32'(stall_flag),          32'd0);
    chk("alu_req",    32'(dmem_req),            32'd0);
    chk("alu_mdata",  mem_data_out,             m_mem_data);
    chk("alu_terr",   32'(timeout_err),         32'(m_terr));
    dmem_ack = 1'b0;
  endtask

  // Squashed memory op: no request, bubble on the WB bundle
  task automatic flush_op();
    alu_result_in = $urandom;
    rd_in         = 5'($urandom);
    reg_write_in  = 1'b1;
    mem_read_in   = 1'($urandom);
    mem_write_in  = 1'b1;
    mem_to_reg_in = 1'($urandom);
    store_data_in = $urandom;
    flush         = 1'b1;
    dmem_ack      = 1'b0;
    @(posedge clk); #1;
    chk("flush_req",   32'(dmem_req),            32'd0);
    chk("flush_stall", 32'(stall_flag),          32'd0);
    chk("flush_rw",    32'(reg_write_out_dm_wb), 32'd0);
    chk("flush_m2r",   32'(mem_to_reg_out),      32'd0);
    flush = 1'b0;
  endtask

  // Memory op answered on ACCESS cycle 'lat' (1..TO); lat==0 means never answered
  task automatic mem_op(input logic rdn, input logic wrn, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic rw, input logic m2r, input int lat,
                        input logic [31:0] rdata);
    int k;
    bit done;
    alu_result_in = addr;
    store_data_in = wdata;
    rd_in         = rd;
    reg_write_in  = rw;
    mem_read_in   = rdn;
    mem_write_in  = wrn;
    mem_to_reg_in = m2r;
    flush         = 1'b0;
    dmem_ack      = 1'b0;
    @(posedge clk); #1;
    chk("mem_issue_req",   32'(dmem_req),            32'd1);
    chk("mem_issue_we",    32'(dmem_we),             32'(wrn));
    chk("mem_issue_addr",  32'(dmem_addr),           32'(addr[AW+1:2]));
    chk("mem_issue_wdata", dmem_wdata,               wdata);
    chk("mem_issue_stall", 32'(stall_flag),          32'd1);
    chk("mem_issue_rw",    32'(reg_write_out_dm_wb), 32'd0);
    k    = 0;
    done = 1'b0;
    while (!done) begin
      k++;
      // Whatever upstream presents while stalled must be ignored
      alu_result_in = $urandom;
      store_data_in = $urandom;
      rd_in         = 5'($urandom);
      mem_read_in   = 1'($urandom);
      mem_write_in  = 1'($urandom);
      reg_write_in  = 1'($urandom);
      mem_to_reg_in = 1'($urandom);
      flush         = 1'($urandom);
      dmem_ack      = (k == lat);
      dmem_rdata    = (k == lat) ? rdata : $urandom;
      @(posedge clk); #1;
      done = (k == lat) || (k >= TO);
      if (!done) begin
        chk("mem_wait_stall", 32'(stall_flag),          32'd1);
        chk("mem_wait_req",   32'(dmem_req),            32'd1);
        chk("mem_wait_addr",  32'(dmem_addr),           32'(addr[AW+1:2]));
        chk("mem_wait_rw",    32'(reg_write_out_dm_wb), 32'd0);
      end
    end
    dmem_ack = 1'b0;
    flush    = 1'b0;
    chk("mem_done_stall", 32'(stall_flag), 32'd0);
    chk("mem_done_req",   32'(dmem_req),   32'd0);
    if (lat != 0) begin
      chk("mem_done_rw",  32'(reg_write_out_dm_wb), 32'(rw));
      chk("mem_done_m2r", 32'(mem_to_reg_out),      wrn ? 32'd0 : 32'(m2r));
      if (!wrn) begin
        m_mem_data = rdata;
        chk("load_rd",  32'(rd_out_dm_wb), 32'(rd));
        chk("load_alu", alu_result_out,    addr);
      end
    end else begin
      m_terr = 1'b1;
      chk("timeout_rw", 32'(reg_write_out_dm_wb), 32'd0);
    end
    chk("mem_done_mdata", mem_data_out,        m_mem_data);
    chk("mem_done_terr",  32'(timeout_err),    32'(m_terr));
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    int          lat;

    reset         = 1'b1;
    alu_result_in = '0;
    store_data_in = '0;
    rd_in         = '0;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    reg_write_in  = 1'b0;
    mem_to_reg_in = 1'b0;
    flush         = 1'b0;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
    m_mem_data    = '0;
    m_terr        = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    #8;
    chk("rst_stall", 32'(stall_flag),          32'd0);
    chk("rst_req",   32'(dmem_req),            32'd0);
    chk("rst_we",    32'(dmem_we),             32'd0);
    chk("rst_addr",  32'(dmem_addr),           32'd0);
    chk("rst_rw",    32'(reg_write_out_dm_wb), 32'd0);
    chk("rst_alu",   alu_result_out,           32'd0);
    chk("rst_mdata", mem_data_out,             32'd0);
    chk("rst_terr",  32'(timeout_err),         32'd0);
    #2 reset = 1'b1;

    // Directed scenarios
    alu_op(5'd3, 1'b1, 32'h5);
    mem_op(1'b1, 1'b0, 32'h10, 32'h0, 5'd4, 1'b1, 1'b1, 2, 32'hDEADBEEF);
    mem_op(1'b0, 1'b1, 32'h20, 32'h1234, 5'd0, 1'b0, 1'b0, 1, 32'h0);
    flush_op();
    mem_op(1'b1, 1'b0, 32'h44, 32'h0, 5'd7, 1'b1, 1'b1, 0, 32'h0);
    alu_op(5'd9, 1'b1, 32'hCAFE_0001);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom;
`ifdef DM_ALIGN_CHECK_EN
      a[1:0] = 2'b00;
`endif
      lat  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
      case (kind)
        0: alu_op(5'($urandom), 1'($urandom), a);
        1: mem_op(1'b1, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom),
                  1'($urandom), lat, $urandom);
        2: mem_op(1'($urandom), 1'b1, a, $urandom, 5'($urandom), 1'($urandom),
                  1'($urandom), lat, $urandom);
        default: flush_op();
      endcase
    end

    // Ensure the sticky flag is set before checking that reset clears it
    mem_op(1'b1, 1'b0, 32'h80, 32'h0, 5'd1, 1'b1, 1'b0, 0, 32'h0);

    // Asynchronous reset in the middle of an access
    alu_result_in = 32'h100;
    rd_in         = 5'd2;
    reg_write_in  = 1'b1;
    mem_read_in   = 1'b1;
    mem_write_in  = 1'b0;
    mem_to_reg_in = 1'b1;
    flush         = 1'b0;
    dmem_ack      = 1'b0;
    @(posedge clk); #1;
    chk("rmid_req_before", 32'(dmem_req), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rmid_req",   32'(dmem_req),            32'd0);
    chk("rmid_stall", 32'(stall_flag),          32'd0);
    chk("rmid_terr",  32'(timeout_err),         32'd0);
    chk("rmid_rw",    32'(reg_write_out_dm_wb), 32'd0);
    chk("rmid_mdata", mem_data_out,             32'd0);
    m_terr     = 1'b0;
    m_mem_data = '0;
    #2 reset = 1'b1;
    alu_op(5'd31, 1'b1, 32'h1357_9BDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
